// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and sizing helpers for the radix-4 Booth multiplier
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Booth digit: zero -> 0, two -> 2M instead of M, neg -> subtract
    typedef struct packed {
        logic zero;
        logic two;
        logic neg;
    } booth_rec_t;

    // Operands carry two guard bits so unsigned values stay positive in the signed recoding
    function automatic int calc_n(input int width);
        return width + 2;
    endfunction

    // Two multiplier bits are retired per iteration
    function automatic int calc_iters(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// rtl/booth_r4_recoder.sv - combinational radix-4 Booth triplet recoder
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] grp,
    output booth_rec_t rec
);

    // Map {q[1], q[0], q_1} onto a digit in {-2,-1,0,+1,+2}
    always_comb begin
        rec = '0;
        case (grp)
            3'b000, 3'b111: rec.zero = 1'b1;
            3'b001, 3'b010: rec = '0;
            3'b011: rec.two = 1'b1;
            3'b100: begin
                rec.two = 1'b1;
                rec.neg = 1'b1;
            end
            3'b101, 3'b110: rec.neg = 1'b1;
            default: rec = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mul.sv
// rtl/booth_r4_mul.sv - sequential radix-4 Booth multiplier with start/done handshake
module booth_r4_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    input  logic                 abort,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N     = calc_n(WIDTH);
    localparam int ITERS = calc_iters(WIDTH);
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ITERS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state;
    state_t          state_next;
    logic [N:0]      a;
    logic [N-1:0]    q;
    logic            q_1;
    logic [N-1:0]    m;
    logic [CW-1:0]   counter;

    logic            accept;
    logic            calc_step;
    logic            last_step;
    logic [N-1:0]    mcand_ext;
    logic [N-1:0]    mplier_ext;
    booth_rec_t      rec;
    logic [N:0]      mag;
    logic [N:0]      pp;
    logic [N:0]      sum;
    logic [N:0]      a_nxt;
    logic [N-1:0]    q_nxt;

    booth_r4_recoder u_recoder (
        .grp (q[1:0] == 2'b00 && !q_1 ? 3'b000 : {q[1:0], q_1}),
        .rec (rec)
    );

    // State register; reset forces IDLE so no done can follow reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; abort only matters in CALC, start wins in DONE
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_next = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (counter == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                state_next = start ? ST_CALC : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept    = ready & start;
    assign calc_step = busy & ~abort;
    assign last_step = calc_step & (counter == '0);

    assign mcand_ext  = signed_mode ? {{2{mcand[WIDTH-1]}}, mcand}   : {2'b00, mcand};
    assign mplier_ext = signed_mode ? {{2{mplier[WIDTH-1]}}, mplier} : {2'b00, mplier};

    // Partial product: pick M or 2M, then invert with carry-in for negative digits
    always_comb begin
        mag = '0;
        if (!rec.zero) begin
            mag = rec.two ? {m, 1'b0} : {m[N-1], m};
        end
        pp    = rec.neg ? ~mag : mag;
        sum   = a + pp + {{N{1'b0}}, rec.neg};
        a_nxt = {{2{sum[N]}}, sum[N:2]};
        q_nxt = {sum[1:0], q[N-1:2]};
    end

    // Operand load on accept, one radix-4 step per CALC cycle, product capture on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            counter <= '0;
            product <= '0;
        end else if (accept) begin
            a       <= '0;
            q       <= mplier_ext;
            q_1     <= 1'b0;
            m       <= mcand_ext;
            counter <= CNT_INIT;
        end else if (calc_step) begin
            a       <= a_nxt;
            q       <= q_nxt;
            q_1     <= q[1];
            counter <= counter - CNT_ONE;
            if (last_step) begin
                product <= {a_nxt[WIDTH-3:0], q_nxt};
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_mul.sv
// tb/tb_booth_r4_mul.sv - self-checking bench for booth_r4_mul at WIDTH=8
module tb_booth_r4_mul;

    localparam int WIDTH = 8;
    localparam int LAT   = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               signed_mode = 1'b0;
    logic [WIDTH-1:0]   mcand = '0;
    logic [WIDTH-1:0]   mplier = '0;
    logic               abort = 1'b0;
    logic               ready;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int checks   = 0;
    int failures = 0;

    booth_r4_mul #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .mcand       (mcand),
        .mplier      (mplier),
        .abort       (abort),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input bit sm, input logic [7:0] x, input logic [7:0] y);
        int r;
        int sx;
        int sy;
        if (sm) begin
            sx = $signed(x);
            sy = $signed(y);
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        r = sx * sy;
        return r[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and return at the first cycle done is seen (lat=-1 on timeout)
    task automatic run_op(input bit sm, input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output int lat);
        for (int w = 0; w < 20 && !ready; w++) step();
        signed_mode = sm;
        mcand       = x;
        mplier      = y;
        start       = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        p   = 'x;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (done) begin
                lat = c;
                p   = product;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({ready, busy, done} !== 3'b100 || product !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: ready/busy/done=%b product=%h, required 100 and 0000",
                     {ready, busy, done}, product);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: done=%b ready=%b, required 0 1", done, ready);
        end
    endtask

    task automatic test_directed();
        bit          sm_t [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0]  x_t  [5]  = '{8'hFD, 8'h80, 8'h7F, 8'hFF, 8'h00};
        logic [7:0]  y_t  [5]  = '{8'h05, 8'h80, 8'h80, 8'hFF, 8'd200};
        logic [15:0] e_t  [5]  = '{16'hFFF1, 16'h4000, 16'hC080, 16'hFE01, 16'h0000};
        logic [15:0] p;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(sm_t[i], x_t[i], y_t[i], p, lat);
            checks++;
            if (p !== e_t[i]) begin
                failures++;
                $display("FAIL directed_product[%0d]: got %h, required %h", i, p, e_t[i]);
            end
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, LAT);
            end
        end
        step();
    endtask

    task automatic test_ignore_start();
        int          ndone = 0;
        int          first = -1;
        logic [15:0] p = 'x;
        for (int w = 0; w < 20 && !ready; w++) step();
        signed_mode = 1'b1;
        mcand       = 8'd7;
        mplier      = 8'hF7;
        start       = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL ignore_busy: busy=%b ready=%b, required 1 0", busy, ready);
        end
        mcand       = 8'd100;
        mplier      = 8'd100;
        signed_mode = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        if (done) begin ndone++; first = 2; p = product; end
        for (int c = 3; c <= 12; c++) begin
            step();
            if (done) begin
                ndone++;
                if (first < 0) begin first = c; p = product; end
            end
        end
        checks++;
        if (p !== 16'hFFC1) begin
            failures++;
            $display("FAIL ignore_product: got %h, required ffc1", p);
        end
        checks++;
        if (ndone !== 1 || first !== LAT) begin
            failures++;
            $display("FAIL ignore_done: count=%0d at cycle %0d, required 1 at %0d", ndone, first, LAT);
        end
    endtask

    task automatic test_abort();
        logic [15:0] p;
        int          lat;
        int          ndone = 0;
        run_op(1'b0, 8'd12, 8'd13, p, lat);
        checks++;
        if (p !== 16'h009C || lat !== LAT) begin
            failures++;
            $display("FAIL abort_setup: got %h lat %0d, required 009c lat %0d", p, lat, LAT);
        end
        signed_mode = 1'b1;
        mcand       = 8'hC3;
        mplier      = 8'h5A;
        start       = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({ready, busy, done} !== 3'b100 || product !== 16'h009C) begin
            failures++;
            $display("FAIL abort_state: ready/busy/done=%b product=%h, required 100 and 009c",
                     {ready, busy, done}, product);
        end
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            step();
        end
        checks++;
        if (ndone !== 0 || product !== 16'h009C) begin
            failures++;
            $display("FAIL abort_no_done: dones=%0d product=%h, required 0 and 009c", ndone, product);
        end
        run_op(1'b1, 8'hC3, 8'h5A, p, lat);
        checks++;
        if (p !== ref_mul(1'b1, 8'hC3, 8'h5A) || lat !== LAT) begin
            failures++;
            $display("FAIL abort_next_op: got %h lat %0d, required %h lat %0d",
                     p, lat, ref_mul(1'b1, 8'hC3, 8'h5A), LAT);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int          lat;
        int          ndone = 0;
        run_op(1'b0, 8'd200, 8'd3, p, lat);
        step();
        signed_mode = 1'b0;
        mcand       = 8'd9;
        mplier      = 8'd9;
        start       = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done} !== 3'b100 || product !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid: ready/busy/done=%b product=%h, required 100 and 0000",
                     {ready, busy, done}, product);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: dones=%0d, required 0", ndone);
        end
        run_op(1'b0, 8'd9, 8'd9, p, lat);
        checks++;
        if (p !== 16'd81 || lat !== LAT) begin
            failures++;
            $display("FAIL reset_mid_next_op: got %h lat %0d, required 0051 lat %0d", p, lat, LAT);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] p1;
        logic [15:0] p2;
        int          lat1;
        int          lat2;
        run_op(1'b1, 8'h81, 8'h7E, p1, lat1);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: ready=%b in done cycle, required 1", ready);
        end
        run_op(1'b0, 8'hA5, 8'h3C, p2, lat2);
        checks++;
        if (p1 !== ref_mul(1'b1, 8'h81, 8'h7E) || lat1 !== LAT) begin
            failures++;
            $display("FAIL b2b_first: got %h lat %0d, required %h lat %0d",
                     p1, lat1, ref_mul(1'b1, 8'h81, 8'h7E), LAT);
        end
        checks++;
        if (p2 !== ref_mul(1'b0, 8'hA5, 8'h3C) || lat2 !== LAT) begin
            failures++;
            $display("FAIL b2b_second: got %h lat %0d, required %h lat %0d",
                     p2, lat2, ref_mul(1'b0, 8'hA5, 8'h3C), LAT);
        end
    endtask

    function automatic logic [7:0] pick_operand();
        logic [7:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    task automatic test_random();
        logic [15:0] p;
        logic [15:0] e;
        logic [7:0]  x;
        logic [7:0]  y;
        bit          sm;
        int          lat;
        for (int i = 0; i < 10000; i++) begin
            sm = 1'($urandom);
            x  = pick_operand();
            y  = pick_operand();
            e  = ref_mul(sm, x, y);
            run_op(sm, x, y, p, lat);
            checks++;
            if (p !== e || lat !== LAT) begin
                failures++;
                $display("FAIL random[%0d]: sm=%0d %h*%h got %h lat %0d, required %h lat %0d",
                         i, sm, x, y, p, lat, e, LAT);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
